// File: rtl/fifo_wr_packer.sv
// Write-side packer for the dual-clock FIFO: gathers IN_W-bit beats into RATIO-lane words
// and hands them to the FIFO write port, stalling the source while a word waits on wfull.
module fifo_wr_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
) (
  input  logic                       wclk,
  input  logic                       rrst_n,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [IN_W*RATIO-1:0]      fifo_wdata,
  output logic                       fifo_winc,
  input  logic                       fifo_wfull,
  output logic [$clog2(RATIO+1)-1:0] fifo_wlanes,
  output logic [CNT_W-1:0]           words_cnt
);

  localparam int W  = IN_W * RATIO;
  localparam int AW = IN_W * (RATIO - 1);
  localparam int LW = $clog2(RATIO + 1);
  localparam int CW = $clog2(RATIO);

  typedef enum logic {
    S_FILL = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [AW-1:0]     acc_reg, acc_next;
  logic [W-1:0]      hold_reg, hold_next;
  logic [LW-1:0]     lanes_reg, lanes_next;
  logic [CNT_W-1:0]  words_reg, words_next;

  logic              pend;
  logic              accept;
  logic              drain;
  logic              complete;
  logic              last_lane;
  logic [W-1:0]      packed_word;

  assign pend      = (state_reg == S_PEND);
  assign in_ready  = !pend || !fifo_wfull;
  assign accept    = in_valid && in_ready;
  assign drain     = pend && !fifo_wfull;
  assign last_lane = (cnt_reg == CW'(RATIO - 1));
  assign complete  = accept && (in_last || last_lane);

  // Word as it would be closed by the current beat: earlier lanes from acc,
  // the beat in lane cnt, everything above forced to zero.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      if (gi < RATIO - 1) begin : g_low
        assign packed_word[gi*IN_W +: IN_W] =
          (cnt_reg == CW'(gi)) ? in_data :
          (cnt_reg >  CW'(gi)) ? acc_reg[gi*IN_W +: IN_W] : '0;
        assign acc_next[gi*IN_W +: IN_W] =
          complete                          ? '0      :
          (accept && (cnt_reg == CW'(gi)))  ? in_data :
                                              acc_reg[gi*IN_W +: IN_W];
      end else begin : g_top
        assign packed_word[gi*IN_W +: IN_W] = last_lane ? in_data : '0;
      end
    end
  endgenerate

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg <= S_FILL;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      hold_reg  <= '0;
      lanes_reg <= '0;
      words_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      hold_reg  <= hold_next;
      lanes_reg <= lanes_next;
      words_reg <= words_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    lanes_next = lanes_reg;
    words_next = words_reg;

    if (drain) begin
      words_next = words_reg + CNT_W'(1);
    end

    // A completing beat may land on the same edge as a drain; the hold then
    // reloads and the write strobe stays high for a back-to-back write.
    if (complete) begin
      state_next = S_PEND;
      hold_next  = packed_word;
      lanes_next = LW'(cnt_reg) + LW'(1);
      cnt_next   = '0;
    end else begin
      if (drain) begin
        state_next = S_FILL;
      end
      if (accept) begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  assign fifo_wdata  = hold_reg;
  assign fifo_winc   = pend;
  assign fifo_wlanes = lanes_reg;
  assign words_cnt   = words_reg;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: beats feed a packing model whose words go to a scoreboard
// queue; a monitor pops and compares on every FIFO write.
module tb_fifo_wr_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int CNT_W = 16;

  logic        wclk = 1'b0;
  logic        rrst_n = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] fifo_wdata;
  logic        fifo_winc;
  logic        fifo_wfull = 1'b0;
  logic [2:0]  fifo_wlanes;
  logic [15:0] words_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  lanes;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          stalls = 0;
  longint      cycle = 0;
  longint      wr_cycle[$];
  logic [31:0] m_word = '0;
  int          m_cnt = 0;

  fifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .wclk        (wclk),
    .rrst_n      (rrst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .fifo_wdata  (fifo_wdata),
    .fifo_winc   (fifo_winc),
    .fifo_wfull  (fifo_wfull),
    .fifo_wlanes (fifo_wlanes),
    .words_cnt   (words_cnt)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cycle++;

  // Scoreboard: a write happens at the coming edge when winc & !wfull.
  always @(negedge wclk) begin
    if (rrst_n && fifo_winc && !fifo_wfull) begin
      n_writes++;
      wr_cycle.push_back(cycle);
      n_assert++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got data=%h lanes=%0d, required no write", fifo_wdata, fifo_wlanes);
      end else begin
        sb_e = sb_q.pop_front();
        if (fifo_wdata !== sb_e.data || fifo_wlanes !== sb_e.lanes) begin
          n_fail++;
          $display("FAIL sb_word: got data=%h lanes=%0d, required data=%h lanes=%0d",
                   fifo_wdata, fifo_wlanes, sb_e.data, sb_e.lanes);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] d, input bit last);
    int budget = 200;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge wclk);
    if (!in_ready) stalls++;
    while (!in_ready && budget > 0) begin
      @(negedge wclk);
      budget--;
    end
    n_assert++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
    end
    @(posedge wclk);
    m_word[m_cnt*8 +: 8] = d;
    if (m_cnt == RATIO - 1 || last) begin
      sb_q.push_back('{data: m_word, lanes: 3'(m_cnt + 1)});
      m_word = '0;
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic test_reset();
    #2 rrst_n = 1'b0;
    #1;
    n_assert++; if (fifo_winc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b, required 0", fifo_winc); end
    n_assert++; if (fifo_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h, required 0", fifo_wdata); end
    n_assert++; if (fifo_wlanes !== 3'd0) begin n_fail++; $display("FAIL reset_wlanes: got %0d, required 0", fifo_wlanes); end
    n_assert++; if (words_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_words_cnt: got %h, required 0", words_cnt); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    repeat (2) @(negedge wclk);
    rrst_n = 1'b1;
    @(posedge wclk); #1;
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    int base = n_writes;
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 0);
    n_assert++; if (fifo_winc !== 1'b1) begin n_fail++; $display("FAIL word_winc_n1: got %b, required 1", fifo_winc); end
    n_assert++; if (fifo_wdata !== 32'h44332211) begin n_fail++; $display("FAIL word_data: got %h, required 44332211", fifo_wdata); end
    n_assert++; if (fifo_wlanes !== 3'd4) begin n_fail++; $display("FAIL word_lanes: got %0d, required 4", fifo_wlanes); end
    @(posedge wclk); #1;
    n_assert++; if (fifo_winc !== 1'b0) begin n_fail++; $display("FAIL word_winc_n2: got %b, required 0", fifo_winc); end
    n_assert++; if (words_cnt !== 16'd1) begin n_fail++; $display("FAIL word_words_cnt: got %0d, required 1", words_cnt); end
    n_assert++; if (n_writes - base != 1) begin n_fail++; $display("FAIL word_write_count: got %0d, required 1", n_writes - base); end
    $display("test_full_word done: data=%h", fifo_wdata);
  endtask

  task automatic test_back_to_back();
    int base = n_writes;
    stalls = 0;
    wr_cycle.delete();
    for (int i = 0; i < 16; i++) send_beat(8'($urandom_range(0, 255)), 0);
    @(posedge wclk); #1;
    n_assert++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d, required 0", stalls); end
    n_assert++; if (n_writes - base != 4) begin n_fail++; $display("FAIL b2b_writes: got %0d, required 4", n_writes - base); end
    if (wr_cycle.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        n_assert++;
        if (wr_cycle[i] - wr_cycle[i-1] != 4) begin
          n_fail++;
          $display("FAIL b2b_gap%0d: got %0d cycles, required 4", i, wr_cycle[i] - wr_cycle[i-1]);
        end
      end
    end
    $display("test_back_to_back done: %0d writes", n_writes - base);
  endtask

  task automatic test_last();
    send_beat(8'hAA, 0); send_beat(8'hBB, 1);
    n_assert++; if (fifo_wdata !== 32'h0000BBAA) begin n_fail++; $display("FAIL last_data: got %h, required 0000BBAA", fifo_wdata); end
    n_assert++; if (fifo_wlanes !== 3'd2) begin n_fail++; $display("FAIL last_lanes: got %0d, required 2", fifo_wlanes); end
    send_beat(8'hCC, 0); send_beat(8'hDD, 0); send_beat(8'hEE, 0); send_beat(8'hFF, 0);
    n_assert++; if (fifo_wdata !== 32'hFFEEDDCC) begin n_fail++; $display("FAIL last_restart: got %h, required FFEEDDCC", fifo_wdata); end
    send_beat(8'h5A, 1);
    n_assert++; if (fifo_wdata !== 32'h0000005A) begin n_fail++; $display("FAIL last_single_data: got %h, required 0000005A", fifo_wdata); end
    n_assert++; if (fifo_wlanes !== 3'd1) begin n_fail++; $display("FAIL last_single_lanes: got %0d, required 1", fifo_wlanes); end
    // in_last without in_valid must not close a word
    in_valid = 1'b0; in_last = 1'b1; in_data = 8'hEE;
    repeat (3) @(posedge wclk);
    #1; in_last = 1'b0;
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 0);
    n_assert++; if (fifo_wlanes !== 3'd4) begin n_fail++; $display("FAIL last_ignored: got lanes=%0d, required 4", fifo_wlanes); end
    @(posedge wclk); #1;
    $display("test_last done");
  endtask

  task automatic test_full();
    int base;
    send_beat(8'hA1, 0); send_beat(8'hA2, 0); send_beat(8'hA3, 0); send_beat(8'hA4, 0);
    fifo_wfull = 1'b1;
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
    base = n_writes;
    for (int i = 0; i < 10; i++) begin
      @(negedge wclk);
      n_assert++; if (fifo_winc !== 1'b1) begin n_fail++; $display("FAIL full_winc c%0d: got %b, required 1", i, fifo_winc); end
      n_assert++; if (fifo_wdata !== 32'hA4A3A2A1) begin n_fail++; $display("FAIL full_data c%0d: got %h, required A4A3A2A1", i, fifo_wdata); end
      n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready c%0d: got %b, required 0", i, in_ready); end
    end
    @(posedge wclk); #1;
    fifo_wfull = 1'b0;
    send_beat(8'h55, 0);
    n_assert++; if (n_writes - base != 1) begin n_fail++; $display("FAIL full_release_writes: got %0d, required 1", n_writes - base); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_release_ready: got %b, required 1", in_ready); end
    n_assert++; if (fifo_winc !== 1'b0) begin n_fail++; $display("FAIL full_release_winc: got %b, required 0", fifo_winc); end
    send_beat(8'h66, 0); send_beat(8'h77, 0); send_beat(8'h88, 0);
    @(posedge wclk); #1;
    n_assert++; if (n_writes - base != 2) begin n_fail++; $display("FAIL full_total_writes: got %0d, required 2", n_writes - base); end
    $display("test_full done");
  endtask

  task automatic test_reset_mid();
    send_beat(8'hDE, 0); send_beat(8'hAD, 0);
    #3 rrst_n = 1'b0;
    #1;
    n_assert++; if (words_cnt !== 16'h0) begin n_fail++; $display("FAIL rst2_words_cnt: got %h, required 0", words_cnt); end
    n_assert++; if (fifo_winc !== 1'b0) begin n_fail++; $display("FAIL rst2_winc: got %b, required 0", fifo_winc); end
    @(negedge wclk); rrst_n = 1'b1; model_clear();
    @(posedge wclk); #1;
    send_beat(8'hC1, 0); send_beat(8'hC2, 0); send_beat(8'hC3, 0); send_beat(8'hC4, 0);
    fifo_wfull = 1'b1;
    #3 rrst_n = 1'b0;
    #1;
    n_assert++; if (fifo_winc !== 1'b0) begin n_fail++; $display("FAIL rstp_winc: got %b, required 0", fifo_winc); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_in_ready: got %b, required 1", in_ready); end
    fifo_wfull = 1'b0;
    @(negedge wclk); rrst_n = 1'b1; model_clear();
    @(posedge wclk); #1;
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 0);
    n_assert++; if (fifo_wdata !== 32'h04030201) begin n_fail++; $display("FAIL rst_post_data: got %h, required 04030201", fifo_wdata); end
    @(posedge wclk); #1;
    n_assert++; if (words_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_post_cnt: got %0d, required 1", words_cnt); end
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    #3 rrst_n = 1'b0;
    @(negedge wclk); rrst_n = 1'b1; model_clear();
    wr_cycle.delete();
    @(posedge wclk); #1;
    for (int i = 0; i < 65535; i++) send_beat(8'(i), 1);
    @(posedge wclk); #1;
    n_assert++; if (words_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h, required FFFF", words_cnt); end
    send_beat(8'h77, 1);
    @(posedge wclk); #1;
    n_assert++; if (words_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h, required 0000", words_cnt); end
    $display("test_wrap done: words_cnt=%h", words_cnt);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_last();
    test_full();
    test_reset_mid();
    test_wrap();
    repeat (2) @(posedge wclk);
    #1;
    n_assert++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d words never written, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
